// File: rtl/line_draw_sequencer.sv
// line_draw_sequencer: per-frame scheduler for the overlay line datapath.
// A frame strobe captures the origin and the N_SEGMENTS offset vectors. Each
// clamped endpoint is then computed in turn, and one origin->endpoint segment
// is handed to line_gen at a time. The next segment is issued only after the
// engine reports that the current one is done.
// Optional build macro: SKIP_ZERO_SEG_EN. When it is defined, segments whose
// clamped endpoint equals the origin are skipped without raising valid.
module line_draw_sequencer #(
    parameter int N_SEGMENTS = 3,
    parameter int H_MAX      = 1280,
    parameter int V_MAX      = 720,
    localparam int IDX_W     = (N_SEGMENTS > 1) ? $clog2(N_SEGMENTS) : 1
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     frame_start_in,
    input  logic [N_SEGMENTS*16-1:0] x_vec_in,
    input  logic [N_SEGMENTS*16-1:0] y_vec_in,
    input  logic [10:0]              x_origin_in,
    input  logic [9:0]               y_origin_in,
    output logic                     seg_valid_out,
    input  logic                     seg_ready_in,
    input  logic                     seg_done_in,
    output logic [10:0]              x0_out,
    output logic [9:0]               y0_out,
    output logic [10:0]              x1_out,
    output logic [9:0]               y1_out,
    output logic [IDX_W-1:0]         seg_idx_out,
    output logic                     busy_out,
    output logic                     frame_done_out,
    output logic                     frame_drop_out
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        WAIT,
        NEXT,
        DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SEGMENTS - 1);

    state_t                  state, state_nxt;
    logic [N_SEGMENTS*16-1:0] x_snap, y_snap;
    logic [10:0]             x0_q, x1_q;
    logic [9:0]              y0_q, y1_q;
    logic [IDX_W-1:0]        seg_idx_q;
    logic                    drop_q;
    logic [15:0]             off_x, off_y;
    logic [10:0]             x1_calc;
    logic [9:0]              y1_calc;
    logic                    is_last;

    // The origin is widened to 17 bits and the signed offset is added with no
    // wrap. Negative results pin to 0 and results past the edge pin to the
    // last pixel.
    function automatic logic [10:0] clamp_x(input logic [10:0] org, input logic [15:0] off);
        logic [16:0] sum;
        sum = {6'd0, org} + {off[15], off};
        if (sum[16])
            clamp_x = '0;
        else if (sum >= 17'(H_MAX))
            clamp_x = 11'(H_MAX - 1);
        else
            clamp_x = sum[10:0];
    endfunction

    function automatic logic [9:0] clamp_y(input logic [9:0] org, input logic [15:0] off);
        logic [16:0] sum;
        sum = {7'd0, org} + {off[15], off};
        if (sum[16])
            clamp_y = '0;
        else if (sum >= 17'(V_MAX))
            clamp_y = 10'(V_MAX - 1);
        else
            clamp_y = sum[9:0];
    endfunction

    // Select the captured offsets of the current segment and clamp its endpoint.
    always_comb begin
        off_x = '0;
        off_y = '0;
        for (int i = 0; i < N_SEGMENTS; i++) begin
            if (seg_idx_q == IDX_W'(i)) begin
                off_x = x_snap[i*16 +: 16];
                off_y = y_snap[i*16 +: 16];
            end
        end
        x1_calc = clamp_x(x0_q, off_x);
        y1_calc = clamp_y(y0_q, off_y);
        is_last = (seg_idx_q == LAST_IDX);
    end

    // State register. Reset abandons any segment that is in flight.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic. A done that arrives in ISSUE is not taken, because only
    // WAIT listens for it.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (frame_start_in) state_nxt = LOAD;
`ifdef SKIP_ZERO_SEG_EN
            LOAD:  begin
                if (x1_calc == x0_q && y1_calc == y0_q)
                    state_nxt = is_last ? DONE : NEXT;
                else
                    state_nxt = ISSUE;
            end
`else
            LOAD:  state_nxt = ISSUE;
`endif
            ISSUE: if (seg_ready_in) state_nxt = WAIT;
            WAIT:  if (seg_done_in) state_nxt = is_last ? DONE : NEXT;
            NEXT:  state_nxt = LOAD;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture the inputs on an accepted strobe, register the endpoint
    // in LOAD, step the index in NEXT, and flag strobes that arrive while busy.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            x_snap    <= '0;
            y_snap    <= '0;
            x0_q      <= '0;
            y0_q      <= '0;
            x1_q      <= '0;
            y1_q      <= '0;
            seg_idx_q <= '0;
            drop_q    <= 1'b0;
        end else begin
            drop_q <= frame_start_in && (state != IDLE);
            case (state)
                IDLE: begin
                    if (frame_start_in) begin
                        x_snap    <= x_vec_in;
                        y_snap    <= y_vec_in;
                        x0_q      <= x_origin_in;
                        y0_q      <= y_origin_in;
                        seg_idx_q <= '0;
                    end
                end
                LOAD: begin
                    x1_q <= x1_calc;
                    y1_q <= y1_calc;
                end
                NEXT: seg_idx_q <= seg_idx_q + IDX_W'(1);
                default: ;
            endcase
        end
    end

    assign seg_valid_out  = (state == ISSUE);
    assign busy_out       = (state != IDLE);
    assign frame_done_out = (state == DONE);
    assign frame_drop_out = drop_q;
    assign x0_out         = x0_q;
    assign y0_out         = y0_q;
    assign x1_out         = x1_q;
    assign y1_out         = y1_q;
    assign seg_idx_out    = seg_idx_q;

endmodule

// File: tb/tb_line_draw_sequencer.sv
// Testbench for line_draw_sequencer. It uses table-driven frames with a
// segment scoreboard, a behavioural line engine, and hand-written sequences
// for throughput, stalls, dropped strobes, ready/done collisions and reset.
module tb_line_draw_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic [47:0] x_vec = '0, y_vec = '0;
    logic [10:0] x_origin = '0;
    logic [9:0]  y_origin = '0;
    logic        seg_ready = 1'b0, seg_done = 1'b0;
    logic        seg_valid, busy, frame_done, frame_drop;
    logic [10:0] x0, x1;
    logic [9:0]  y0, y1;
    logic [1:0]  seg_idx;

    line_draw_sequencer dut (
        .clk_in(clk), .rst_n_in(rst_n), .frame_start_in(frame_start),
        .x_vec_in(x_vec), .y_vec_in(y_vec), .x_origin_in(x_origin), .y_origin_in(y_origin),
        .seg_valid_out(seg_valid), .seg_ready_in(seg_ready), .seg_done_in(seg_done),
        .x0_out(x0), .y0_out(y0), .x1_out(x1), .y1_out(y1), .seg_idx_out(seg_idx),
        .busy_out(busy), .frame_done_out(frame_done), .frame_drop_out(frame_drop)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  idx;
        logic [10:0] x0, x1;
        logic [9:0]  y0, y1;
    } seg_t;

    typedef struct {
        logic [10:0]      xo;
        logic [9:0]       yo;
        logic [47:0]      xv, yv;
        logic [2:0][10:0] ex;
        logic [2:0][9:0]  ey;
    } vec_t;

    seg_t sbq[$];
    int   hcyc[$];
    vec_t vt[6];
    int   cyc = 0, handoffs = 0, done_seen = 0;

    always @(posedge clk) cyc++;

    // Line engine: it can hold ready low, return done after a delay, and
    // optionally raise done together with ready.
    int rdy_hold = 0, done_dly = 0;
    bit ready_always = 0, done_with_ready = 0;
    initial begin : engine
        int hold_cnt, dcnt;
        bit pend, armed;
        hold_cnt = 0; dcnt = 0; pend = 0; armed = 0;
        forever begin
            @(posedge clk); #1;
            seg_done = 1'b0;
            if (!rst_n) begin
                pend = 0; armed = 0; hold_cnt = 0; seg_ready = 1'b0;
            end else begin
                if (pend) begin
                    pend = 0; armed = 1; dcnt = done_dly;
                end
                if (armed) begin
                    chk("no_valid_before_done", seg_valid, 0);
                    if (dcnt == 0) begin seg_done = 1'b1; armed = 0; end
                    else dcnt--;
                end
                if (seg_valid && !armed) begin
                    if (!ready_always && hold_cnt < rdy_hold) begin
                        seg_ready = 1'b0; hold_cnt++;
                    end else begin
                        seg_ready = 1'b1; hold_cnt = 0; pend = 1;
                        if (done_with_ready) seg_done = 1'b1;
                    end
                end else begin
                    seg_ready = ready_always;
                end
            end
        end
    end

    // Monitor: scores each handoff against the scoreboard and checks that
    // outputs hold steady while a valid segment is stalled.
    initial begin : monitor
        bit pv, pho;
        logic [10:0] px0, px1;
        logic [9:0]  py0, py1;
        logic [1:0]  pidx;
        seg_t e;
        pv = 0; pho = 0; px0 = '0; px1 = '0; py0 = '0; py1 = '0; pidx = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) pv = 0;
            else begin
                if (pv && !pho && seg_valid)
                    chk("stall_stable", (x0 == px0 && y0 == py0 && x1 == px1 && y1 == py1 && seg_idx == pidx), 1);
                if (seg_valid && seg_ready) begin
                    handoffs++;
                    hcyc.push_back(cyc);
                    if (sbq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_seg actual=idx%0d required=none", seg_idx);
                    end else begin
                        e = sbq.pop_front();
                        chk("seg_idx", seg_idx, e.idx);
                        chk("x0", x0, e.x0);
                        chk("y0", y0, e.y0);
                        chk("x1", x1, e.x1);
                        chk("y1", y1, e.y1);
                    end
                end
                if (frame_done) done_seen++;
                pv = seg_valid; pho = seg_valid && seg_ready;
                px0 = x0; px1 = x1; py0 = y0; py1 = y1; pidx = seg_idx;
            end
        end
    end

    task automatic push_exp(input vec_t v);
        seg_t s;
        for (int i = 0; i < 3; i++) begin
`ifdef SKIP_ZERO_SEG_EN
            if (v.ex[i] == v.xo && v.ey[i] == v.yo) continue;
`endif
            s.idx = 2'(i); s.x0 = v.xo; s.y0 = v.yo; s.x1 = v.ex[i]; s.y1 = v.ey[i];
            sbq.push_back(s);
        end
    endtask

    task automatic start_frame(input vec_t v);
        bit first0;
        push_exp(v);
        first0 = (sbq.size() > 0) && (sbq[0].idx == 2'd0);
        @(posedge clk); #1;
        x_origin = v.xo; y_origin = v.yo; x_vec = v.xv; y_vec = v.yv;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        x_vec = {16'($urandom), 16'($urandom), 16'($urandom)};
        y_vec = {16'($urandom), 16'($urandom), 16'($urandom)};
        x_origin = 11'($urandom); y_origin = 10'($urandom);
        chk("busy_after_start", busy, 1);
        chk("valid_low_in_load", seg_valid, 0);
        chk("x0_latched", x0, v.xo);
        @(posedge clk); #1;
        chk("first_valid", seg_valid, first0);
    endtask

    task automatic finish_frame(input int d0);
        bit got;
        got = 0;
        for (int i = 0; i < 600 && !got; i++) begin
            @(posedge clk); #1;
            if (done_seen != d0) got = 1;
        end
        chk("frame_done_seen", got, 1);
        chk("busy_cleared", busy, 0);
        chk("done_one_cycle", frame_done, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("done_count", done_seen - d0, 1);
        chk("sb_empty", sbq.size(), 0);
        sbq.delete();
    endtask

    task automatic run_frame(input vec_t v);
        int d0;
        d0 = done_seen;
        start_frame(v);
        finish_frame(d0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, seg_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, frame_done, 0);
        chk({tag, "_drop"}, frame_drop, 0);
        chk({tag, "_x0"}, x0, 0);
        chk({tag, "_y0"}, y0, 0);
        chk({tag, "_x1"}, x1, 0);
        chk({tag, "_y1"}, y1, 0);
        chk({tag, "_idx"}, seg_idx, 0);
    endtask

    initial begin : main
        int d0, h0;
        vt[0] = '{11'd100, 10'd50, {16'd3, 16'd8, 16'd9}, {16'd5, 16'd2, 16'd4},
                  {11'd103, 11'd108, 11'd109}, {10'd55, 10'd52, 10'd54}};
        vt[1] = '{11'd1275, 10'd2, {16'd4, 16'hFFFE, 16'd20}, {16'd0, 16'd3, 16'hFFF6},
                  {11'd1279, 11'd1273, 11'd1279}, {10'd2, 10'd5, 10'd0}};
        vt[2] = '{11'd5, 10'd715, {16'd10, 16'hFFFB, 16'h8000}, {16'hFD35, 16'd4, 16'h7FFF},
                  {11'd15, 11'd0, 11'd0}, {10'd0, 10'd719, 10'd719}};
        vt[3] = '{11'd100, 10'd50, {16'd0, 16'd8, 16'd0}, {16'd0, 16'd2, 16'd0},
                  {11'd100, 11'd108, 11'd100}, {10'd50, 10'd52, 10'd50}};
        vt[4] = '{11'd1279, 10'd719, {16'hFB01, 16'd0, 16'd1}, {16'hFD31, 16'd0, 16'd1},
                  {11'd0, 11'd1279, 11'd1279}, {10'd0, 10'd719, 10'd719}};
        vt[5] = '{11'd640, 10'd360, 48'd0, 48'd0,
                  {11'd640, 11'd640, 11'd640}, {10'd360, 10'd360, 10'd360}};

        #1;
        chk_all_zero("reset");
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_release", {busy, seg_valid}, 0);

        // Table of frames with a mix of ready stalls and done delays.
        for (int v = 0; v < 6; v++) begin
            rdy_hold = (v % 2 == 1) ? 2 : 0;
            done_dly = (v == 0) ? 3 : v;
            run_frame(vt[v]);
        end
        rdy_hold = 0;

        // With a zero-latency engine, handoffs are four cycles apart.
        ready_always = 1; done_dly = 0;
        hcyc.delete();
        run_frame(vt[0]);
        chk("tput_handoffs", hcyc.size(), 3);
        if (hcyc.size() >= 3) begin
            chk("tput_gap0", hcyc[1] - hcyc[0], 4);
            chk("tput_gap1", hcyc[2] - hcyc[1], 4);
        end
        ready_always = 0;

        // Hold ready low for 10 cycles per segment. There must be one
        // handoff per segment.
        rdy_hold = 10; done_dly = 2;
        h0 = handoffs;
        run_frame(vt[0]);
        chk("stall_handoffs", handoffs - h0, 3);
        rdy_hold = 0;

        // A second strobe in mid-frame is dropped for exactly one cycle.
        done_dly = 6;
        d0 = done_seen;
        start_frame(vt[1]);
        repeat (2) @(posedge clk);
        #1;
        frame_start = 1'b1; x_origin = 11'd7; y_origin = 10'd9;
        @(posedge clk); #1;
        frame_start = 1'b0;
        chk("drop_pulse", frame_drop, 1);
        @(posedge clk); #1;
        chk("drop_one_cycle", frame_drop, 0);
        finish_frame(d0);
        repeat (10) @(posedge clk);
        #1;
        chk("no_frame_after_drop", busy, 0);

        // Ready and done arrive together in ISSUE. The done must be ignored.
        done_with_ready = 1; done_dly = 4;
        run_frame(vt[0]);
        done_with_ready = 0;

        // Assert reset while in WAIT of segment 1.
        done_dly = 20;
        h0 = handoffs;
        start_frame(vt[0]);
        for (int i = 0; i < 200 && handoffs < h0 + 2; i++) begin
            @(posedge clk); #1;
        end
        chk("reached_seg1", handoffs - h0, 2);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        sbq.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("idle_until_start", {busy, seg_valid, frame_done}, 0);
        end

        // After reset, a normal frame must run.
        done_dly = 1;
        run_frame(vt[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
